// File: rtl/i2c_target_regs_if.sv
// i2c_target_regs_if: open-drain I2C pins plus the register-file port of the I2C target
interface i2c_target_regs_if #(parameter int REG_AW = 4);
    logic              scl_in;
    logic              sda_in;
    logic              sda_oe;
    logic [REG_AW-1:0] reg_addr;
    logic [7:0]        reg_wdata;
    logic              reg_we;
    logic              reg_re;
    logic [7:0]        reg_rdata;
    logic              busy;
    modport slave  (input scl_in, sda_in, reg_rdata, output sda_oe, reg_addr, reg_wdata, reg_we, reg_re, busy);
    modport master (output scl_in, sda_in, reg_rdata, input sda_oe, reg_addr, reg_wdata, reg_we, reg_re, busy);
endinterface

// File: rtl/i2c_target_regs.sv
// i2c_target_regs: oversampled I2C target giving an external controller access to a register file
module i2c_target_regs #(
    parameter logic [6:0] DEV_ADDR = 7'h70,
    parameter int         REG_AW   = 4
) (
    input logic              clk,
    input logic              rst_n,
    i2c_target_regs_if.slave bus
);
    typedef enum logic [3:0] {IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RD_ACK} state_t;
    state_t            r_state;
    logic [2:0]        r_scl, r_sda;
    logic [3:0]        r_cnt;
    logic [7:0]        r_shift;
    logic              r_rw, r_ack, r_sda_oe, r_we, r_re, r_busy;
    logic [REG_AW-1:0] r_addr;
    logic [7:0]        r_wdata;
    logic              w_scl_rise, w_scl_fall, w_start, w_stop, w_byte, w_rx, w_match;
    assign w_scl_rise = r_scl[1] & ~r_scl[2];
    assign w_scl_fall = ~r_scl[1] & r_scl[2];
    assign w_start    = r_scl[1] & r_scl[2] & ~r_sda[1] & r_sda[2];
    assign w_stop     = r_scl[1] & r_scl[2] & r_sda[1] & ~r_sda[2];
    assign w_byte     = r_cnt == 4'd8;
    assign w_rx       = r_state == ADDR || r_state == PTR || r_state == WDATA;
    assign w_match    = r_shift[7:1] == DEV_ADDR;
    assign bus.sda_oe    = r_sda_oe;
    assign bus.reg_addr  = r_addr;
    assign bus.reg_wdata = r_wdata;
    assign bus.reg_we    = r_we;
    assign bus.reg_re    = r_re;
    assign bus.busy      = r_busy;
    // Read bytes load one clk after the SCL_FALL that pulses reg_re, so reg_rdata reflects the updated pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_scl    <= 3'b111;
            r_sda    <= 3'b111;
            r_cnt    <= '0;
            r_shift  <= '0;
            r_rw     <= 1'b0;
            r_ack    <= 1'b0;
            r_sda_oe <= 1'b0;
            r_we     <= 1'b0;
            r_re     <= 1'b0;
            r_busy   <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
        end else begin
            r_scl <= {r_scl[1:0], bus.scl_in};
            r_sda <= {r_sda[1:0], bus.sda_in};
            r_we  <= 1'b0;
            r_re  <= 1'b0;
            if (w_start) begin
                r_state  <= ADDR;
                r_cnt    <= '0;
                r_sda_oe <= 1'b0;
                r_busy   <= 1'b0;
            end else if (w_stop) begin
                r_state  <= IDLE;
                r_sda_oe <= 1'b0;
                r_busy   <= 1'b0;
            end else if (w_rx && w_scl_rise) begin
                r_shift <= {r_shift[6:0], r_sda[1]};
                r_cnt   <= r_cnt + 4'd1;
            end else if (r_state == RD_ACK && w_scl_rise) begin
                r_ack <= ~r_sda[1];
            end else if (r_state == RDATA && r_re) begin
                r_shift  <= bus.reg_rdata;
                r_sda_oe <= ~bus.reg_rdata[7];
                r_cnt    <= '0;
            end else if (w_scl_fall) begin
                case (r_state)
                    ADDR: if (w_byte) begin
                        r_state  <= w_match ? ADDR_ACK : IDLE;
                        r_sda_oe <= w_match;
                        r_busy   <= w_match;
                        r_rw     <= r_shift[0];
                    end
                    ADDR_ACK: begin
                        r_state  <= r_rw ? RDATA : PTR;
                        r_sda_oe <= 1'b0;
                        r_re     <= r_rw;
                        r_cnt    <= '0;
                    end
                    PTR: if (w_byte) begin
                        r_addr   <= r_shift[REG_AW-1:0];
                        r_sda_oe <= 1'b1;
                        r_state  <= PTR_ACK;
                    end
                    PTR_ACK: begin
                        r_sda_oe <= 1'b0;
                        r_cnt    <= '0;
                        r_state  <= WDATA;
                    end
                    WDATA: if (w_byte) begin
                        r_wdata  <= r_shift;
                        r_we     <= 1'b1;
                        r_sda_oe <= 1'b1;
                        r_state  <= WDATA_ACK;
                    end
                    WDATA_ACK: begin
                        r_sda_oe <= 1'b0;
                        r_cnt    <= '0;
                        r_addr   <= r_addr + REG_AW'(1);
                        r_state  <= WDATA;
                    end
                    RDATA: begin
                        r_state  <= r_cnt == 4'd7 ? RD_ACK : RDATA;
                        r_sda_oe <= r_cnt == 4'd7 ? 1'b0 : ~r_shift[6];
                        r_shift  <= {r_shift[6:0], 1'b0};
                        r_cnt    <= r_cnt + 4'd1;
                    end
                    RD_ACK: begin
                        r_state  <= r_ack ? RDATA : IDLE;
                        r_busy   <= r_ack;
                        r_re     <= r_ack;
                        r_sda_oe <= 1'b0;
                        r_addr   <= r_ack ? r_addr + REG_AW'(1) : r_addr;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
